// File: rtl/seq_pkg.sv
// Shared definitions for the fetch sequencer and the instruction decoder.
//   seq_state_e : sequencer state encoding (2 bits)
//   OP_*        : 3-bit opcode values as produced by the decoder
package seq_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StJtgt   = 2'b10,
    StHalted = 2'b11
  } seq_state_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LD  = 3'b101;
  localparam logic [2:0] OP_ST  = 3'b110;
  localparam logic [2:0] OP_BNE = 3'b111;

endpackage

// File: rtl/fetch_sequencer.sv
// Program counter and fetch sequencer for the 9-bit single-cycle core.
// Owns the PC, flags the word after a taken BNE as an absolute jump target,
// sequences idle/run/halt and counts cycles spent executing.
//
// Ports:
//   CLK, Reset_n  : clock (rising edge), asynchronous active-low reset
//   Start         : one-cycle pulse, begins execution at START_ADDR
//   instruction   : word at PC from instruction memory (combinational)
//   opcode, Halt  : decoder outputs for the current word
//   branch_taken  : ALU not-equal result, only meaningful for BNE
//   PC            : instruction memory address
//   read_jump     : current word is a jump target (decoder must not execute it)
//   run           : core enable, gates register-file and data-memory writes
//   Done          : program halted, held until the next Start
//   cycle_count   : saturating count of RUN/JTGT cycles since the last Start
module fetch_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned          PC_W       = 9,
  parameter logic [PC_W-1:0]      START_ADDR = '0,
  parameter int unsigned          CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [8:0]       instruction,
  input  logic [2:0]       opcode,
  input  logic             Halt,
  input  logic             branch_taken,
  output logic [PC_W-1:0]  PC,
  output logic             read_jump,
  output logic             run,
  output logic             Done,
  output logic [CNT_W-1:0] cycle_count
);

  seq_state_e       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [PC_W-1:0]  jump_target;

  // Jump target is the low PC_W bits of the word, zero-extended for wide PCs.
  if (PC_W > 9) begin : g_target_zext
    assign jump_target = {{(PC_W-9){1'b0}}, instruction};
  end else begin : g_target_trunc
    assign jump_target = instruction[PC_W-1:0];
  end

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StHalted: begin
        if (Start) begin
          state_d = StRun;
          pc_d    = START_ADDR;
          cnt_d   = '0;
        end
      end
      StRun: begin
        cnt_d = cnt_inc;
        if (Halt) begin
          state_d = StHalted;
        end else if (opcode == OP_BNE && branch_taken) begin
          state_d = StJtgt;
          pc_d    = pc_q + PC_W'(1);
        end else if (opcode == OP_BNE) begin
          // Untaken: skip over the target word.
          pc_d    = pc_q + PC_W'(2);
        end else begin
          pc_d    = pc_q + PC_W'(1);
        end
      end
      StJtgt: begin
        cnt_d   = cnt_inc;
        pc_d    = jump_target;
        state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore outputs decoded from state so reset clears them without a clock edge.
  assign PC          = pc_q;
  assign cycle_count = cnt_q;
  assign run         = (state_q == StRun) || (state_q == StJtgt);
  assign read_jump   = (state_q == StJtgt);
  assign Done        = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  typedef struct {
    logic        start;
    logic [8:0]  instr;
    logic        halt;
    logic        bt;
    logic [8:0]  pc;
    logic        rj;
    logic        run;
    logic        done;
    logic [15:0] cnt;
  } vec_t;

  localparam logic [8:0] W_ADD = 9'h000;
  localparam logic [8:0] W_HLT = 9'h080;
  localparam logic [8:0] W_BNE = 9'h1C0;

  int n_cmp = 0;
  int n_bad = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: default widths
  logic        rst0_n, start0, halt0, bt0;
  logic [8:0]  instr0;
  logic [2:0]  op0;
  logic [8:0]  pc0;
  logic        rj0, run0, done0;
  logic [15:0] cnt0;

  // DUT 1: narrow PC, nonzero start address, narrow counter
  logic        rst1_n, start1, halt1, bt1;
  logic [8:0]  instr1;
  logic [2:0]  op1;
  logic [3:0]  pc1;
  logic        rj1, run1, done1;
  logic [3:0]  cnt1;

  fetch_sequencer u_dut0 (
    .CLK          (clk),
    .Reset_n      (rst0_n),
    .Start        (start0),
    .instruction  (instr0),
    .opcode       (op0),
    .Halt         (halt0),
    .branch_taken (bt0),
    .PC           (pc0),
    .read_jump    (rj0),
    .run          (run0),
    .Done         (done0),
    .cycle_count  (cnt0)
  );

  fetch_sequencer #(
    .PC_W       (4),
    .START_ADDR (4'd14),
    .CNT_W      (4)
  ) u_dut1 (
    .CLK          (clk),
    .Reset_n      (rst1_n),
    .Start        (start1),
    .instruction  (instr1),
    .opcode       (op1),
    .Halt         (halt1),
    .branch_taken (bt1),
    .PC           (pc1),
    .read_jump    (rj1),
    .run          (run1),
    .Done         (done1),
    .cycle_count  (cnt1)
  );

  function automatic vec_t mk(logic s, logic [8:0] i, logic h, logic b, logic [8:0] p,
                              logic r, logic ru, logic d, logic [15:0] c);
    vec_t v;
    v.start = s; v.instr = i; v.halt = h; v.bt = b;
    v.pc = p; v.rj = r; v.run = ru; v.done = d; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input int d, input string tag, input vec_t v);
    if (d == 0) begin
      chk({tag, ".pc"},   32'(pc0),   32'(v.pc));
      chk({tag, ".rj"},   32'(rj0),   32'(v.rj));
      chk({tag, ".run"},  32'(run0),  32'(v.run));
      chk({tag, ".done"}, 32'(done0), 32'(v.done));
      chk({tag, ".cnt"},  32'(cnt0),  32'(v.cnt));
    end else begin
      chk({tag, ".pc"},   32'(pc1),   32'(v.pc));
      chk({tag, ".rj"},   32'(rj1),   32'(v.rj));
      chk({tag, ".run"},  32'(run1),  32'(v.run));
      chk({tag, ".done"}, 32'(done1), 32'(v.done));
      chk({tag, ".cnt"},  32'(cnt1),  32'(v.cnt));
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then check the Moore
  // outputs for the current state before the next rising edge.
  task automatic apply(input int d, input int idx, input vec_t v);
    @(negedge clk);
    if (d == 0) begin
      start0 = v.start; instr0 = v.instr; op0 = v.instr[8:6]; halt0 = v.halt; bt0 = v.bt;
    end else begin
      start1 = v.start; instr1 = v.instr; op1 = v.instr[8:6]; halt1 = v.halt; bt1 = v.bt;
    end
    #1;
    check_outs(d, $sformatf("d%0d.v%0d", d, idx), v);
  endtask

  vec_t tab0[$];
  vec_t tab1[$];

  initial begin
    rst0_n = 1'b0; start0 = 1'b0; instr0 = '0; op0 = '0; halt0 = 1'b0; bt0 = 1'b0;
    rst1_n = 1'b0; start1 = 1'b0; instr1 = '0; op1 = '0; halt1 = 1'b0; bt1 = 1'b0;

    // DUT 0: ADD program with halt, restart, taken/untaken BNE, halt priority
    tab0.push_back(mk(0, W_ADD,  0, 0,  0, 0, 0, 0, 0));
    tab0.push_back(mk(1, W_ADD,  0, 0,  0, 0, 0, 0, 0));
    tab0.push_back(mk(0, W_ADD,  0, 0,  0, 0, 1, 0, 0));
    tab0.push_back(mk(1, W_ADD,  0, 0,  1, 0, 1, 0, 1));  // Start ignored in RUN
    tab0.push_back(mk(0, W_ADD,  0, 0,  2, 0, 1, 0, 2));
    tab0.push_back(mk(0, W_ADD,  0, 0,  3, 0, 1, 0, 3));
    tab0.push_back(mk(0, W_HLT,  1, 0,  4, 0, 1, 0, 4));
    tab0.push_back(mk(0, W_ADD,  0, 0,  4, 0, 0, 1, 5));
    tab0.push_back(mk(1, W_ADD,  0, 0,  4, 0, 0, 1, 5));  // restart from HALTED
    tab0.push_back(mk(0, W_ADD,  0, 0,  0, 0, 1, 0, 0));
    tab0.push_back(mk(0, W_ADD,  0, 0,  1, 0, 1, 0, 1));
    tab0.push_back(mk(0, W_BNE,  0, 1,  2, 0, 1, 0, 2));
    tab0.push_back(mk(1, 9'h014, 1, 0,  3, 1, 1, 0, 3));  // JTGT ignores Halt/Start
    tab0.push_back(mk(0, W_BNE,  0, 0, 20, 0, 1, 0, 4));
    tab0.push_back(mk(0, W_BNE,  1, 1, 22, 0, 1, 0, 5));  // Halt beats BNE
    tab0.push_back(mk(0, W_ADD,  0, 0, 22, 0, 0, 1, 6));
    tab0.push_back(mk(1, W_ADD,  0, 0, 22, 0, 0, 1, 6));
    tab0.push_back(mk(0, W_ADD,  0, 0,  0, 0, 1, 0, 0));
    tab0.push_back(mk(0, W_ADD,  0, 0,  1, 0, 1, 0, 1));
    tab0.push_back(mk(0, W_BNE,  0, 1,  2, 0, 1, 0, 2));
    tab0.push_back(mk(0, 9'h014, 0, 0,  3, 1, 1, 0, 3));  // left in JTGT

    // DUT 1: PC_W=4, START_ADDR=14, CNT_W=4
    tab1.push_back(mk(1, W_ADD,  0, 0,  0, 0, 0, 0, 0));
    tab1.push_back(mk(0, W_ADD,  0, 0, 14, 0, 1, 0, 0));
    tab1.push_back(mk(0, W_BNE,  0, 1, 15, 0, 1, 0, 1));  // BNE at last address
    tab1.push_back(mk(0, 9'h005, 0, 0,  0, 1, 1, 0, 2));  // target fetched from 0
    for (int k = 0; k < 12; k++) begin
      tab1.push_back(mk(0, W_ADD, 0, 0, 9'((5 + k) % 16), 0, 1, 0, 16'(3 + k)));
    end
    tab1.push_back(mk(0, W_ADD,  0, 0,  1, 0, 1, 0, 15)); // saturated
    tab1.push_back(mk(0, W_HLT,  1, 0,  2, 0, 1, 0, 15));
    tab1.push_back(mk(1, W_ADD,  0, 0,  2, 0, 0, 1, 15));
    tab1.push_back(mk(0, W_ADD,  0, 0, 14, 0, 1, 0, 0));
    tab1.push_back(mk(0, W_BNE,  0, 0, 15, 0, 1, 0, 1));  // untaken from 15 -> 1
    tab1.push_back(mk(0, W_ADD,  0, 0,  1, 0, 1, 0, 2));

    // Reset state observed while reset is held
    #2;
    check_outs(0, "rst0", mk(0, W_ADD, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst0_n = 1'b1;

    for (int i = 0; i < tab0.size(); i++) apply(0, i, tab0[i]);

    // Asynchronous reset while in JTGT, no clock edge in between
    rst0_n = 1'b0;
    #1;
    check_outs(0, "rst_jtgt", mk(0, W_ADD, 0, 0, 0, 0, 0, 0, 0));

    // Start held during reset across a rising edge: reset wins
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    rst0_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_outs(0, "post_rst_idle", mk(0, W_ADD, 0, 0, 0, 0, 0, 0, 0));

    rst1_n = 1'b1;
    for (int i = 0; i < tab1.size(); i++) apply(1, i, tab1[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Program-counter and fetch sequencer for the 9-bit single-cycle core. It owns the PC, drives the instruction memory address, and generates read_jump to the instruction decoder so that the word following a taken BNE is treated as an absolute jump target. It also handles run/halt/start sequencing, including the Done handshake to the testbench, and keeps a cycle counter.

Parameters:
PC_W, 9, PC / instruction-memory address width; jump target is instruction[PC_W-1:0], zero-extended if PC_W > 9.
START_ADDR, 0, PC value loaded on Start.
CNT_W, 16, cycle counter width.

Ports:
CLK  in  1  core clock, rising edge.
Reset_n  in  1  asynchronous, active-low reset.
Start  in  1  single-cycle pulse that begins execution at START_ADDR.
instruction  in  9  instruction word read combinationally from instruction memory at PC.
opcode  in  3  decoded opcode from the instruction decoder.
Halt  in  1  halt decode from the instruction decoder.
branch_taken  in  1  ALU comparison result, operands not equal; sampled only for BNE.
PC  out  PC_W  instruction memory address.
read_jump  out  1  to the decoder: the current word is a jump target.
run  out  1  core enable; register-file and data-memory writes are gated with it.
Done  out  1  program halted; held high until the next Start.
cycle_count  out  CNT_W  cycles spent in RUN or JTGT since the last Start.

Behaviour:
- States: IDLE, RUN, JTGT, HALTED, encoded as 2 bits.
- Reset (async, Reset_n=0) sets: state=IDLE, PC=0, read_jump=0, run=0, Done=0, cycle_count=0. Reset asserted mid-program aborts immediately; no partial state survives.
- Outputs are Moore:
  - run=1 in RUN and JTGT.
  - read_jump=1 only in JTGT.
  - Done=1 only in HALTED.
- IDLE:
  - Start=1 -> RUN, PC<=START_ADDR, cycle_count<=0.
- RUN (instruction at PC executes this cycle). Priority order:
  - Halt=1 -> HALTED; PC holds.
  - opcode==3'b111 and branch_taken=1 -> JTGT; PC<=PC+1.
  - opcode==3'b111 and branch_taken=0 -> stay in RUN; PC<=PC+2, skipping the target word.
  - otherwise -> stay in RUN; PC<=PC+1.
  - Start is ignored in RUN.
- JTGT:
  - PC<=instruction[PC_W-1:0], state -> RUN, unconditionally.
  - Halt and opcode inputs are ignored; the decoder drives no writes.
  - Start is ignored.
- HALTED:
  - PC and cycle_count hold.
  - Start=1 -> RUN, PC<=START_ADDR, cycle_count<=0.
- PC arithmetic is modulo 2^PC_W.
  - PC+1 from all-ones wraps to 0.
  - PC+2 from 2^PC_W-1 wraps to 1.
  - A BNE at the last address fetches its target from address 0.
- cycle_count increments on every clock in RUN or JTGT and saturates at all-ones; no wrap.
- Latency: Start to first instruction executing = 1 cycle. A taken BNE costs 2 cycles (BNE + JTGT); an untaken BNE costs 1.
- Start coincident with Reset_n=0: reset wins.

Decomposition:
- Shared package seq_pkg:
  - state enum typedef;
  - opcode constants OP_ADD..OP_BNE (3'b000..3'b111), shared with the decoder.
- Single module, no sub-module; the counter is inline.

Test Plan:
- Reset, then Start with a ROM of 4 ADDs followed by a halt word (9'b010000000) at address 4 -> PC steps 0,1,2,3,4; Done rises the cycle after PC=4; cycle_count=5; run=0 in HALTED.
- BNE at address 2 with branch_taken=1, word 9'h014 at address 3 -> PC sequence 2,3,0x14; read_jump=1 only while PC=3.
- Same BNE with branch_taken=0 -> PC sequence 2,4; read_jump never asserts.
- PC_W=4, BNE at address 15 taken, target word at address 0 = 9'h005 -> PC sequence 15,0,5; untaken case gives 15,1.
- Halt reached, then Start pulsed -> Done drops; PC=START_ADDR; cycle_count restarts at 0. Start pulsed during RUN -> no effect on PC.
- Reset_n pulled low while in JTGT -> all outputs reach reset values without waiting for a clock edge; after release, state remains IDLE until Start.
